seg7_capture: RTL and testbench

- Receive-side counterpart of the two-digit multiplexed 7-segment driver.
- Monitors the anode strobes and active-low cathode lines and recovers the displayed 2-digit BCD value.
- Used for board loopback self-test and bench checking of the display path.
- Flags illegal segment patterns, illegal anode codes, and a display that has stopped refreshing.

---
 rtl/seg7_capture.sv | 169 ++++++++++++++++
 tb/tb_seg7_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: recovers the 2-digit BCD value shown on a multiplexed,
// active-low 7-segment display by watching its anode and cathode lines.
module seg7_capture #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] anodo_i,
  input  logic [6:0] catodo_i,
  output logic [7:0] bcd_o,
  output logic       valid_o,
  output logic       seg_err_o,
  output logic       anode_err_o,
  output logic       stale_o
);

  localparam int unsigned SAMP_W = 9;
  localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HAVE_U,
    ST_HAVE_T,
    ST_COMPLETE
  } state_e;

  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stb_q, stb_d;
  state_e            state_q, state_d;
  logic [3:0]        units_q, units_d;
  logic [3:0]        tens_q, tens_d;
  logic [7:0]        bcd_q, bcd_d;
  logic              valid_q, valid_d;
  logic              seg_err_q, seg_err_d;
  logic              anode_err_q, anode_err_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              stale_q, stale_d;

  logic [4:0]        dec;
  logic [1:0]        samp_an;

  // Active-low segment pattern to {valid, digit}.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'h40:   return {1'b1, 4'd0};
      7'h79:   return {1'b1, 4'd1};
      7'h24:   return {1'b1, 4'd2};
      7'h30:   return {1'b1, 4'd3};
      7'h19:   return {1'b1, 4'd4};
      7'h12:   return {1'b1, 4'd5};
      7'h02:   return {1'b1, 4'd6};
      7'h78:   return {1'b1, 4'd7};
      7'h00:   return {1'b1, 4'd8};
      7'h10:   return {1'b1, 4'd9};
      default: return 5'b0_0000;
    endcase
  endfunction

  // Input sampling, stability counting and single-shot acceptance strobe.
  always_comb begin
    samp_d = {anodo_i, catodo_i};
    cnt_d  = cnt_q;
    if (samp_d != samp_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    stb_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  assign dec     = decode_seg(samp_q[6:0]);
  assign samp_an = samp_q[8:7];

  // Digit-pair FSM: next state, slot writes, flags and output value.
  always_comb begin
    state_d     = state_q;
    units_d     = units_q;
    tens_d      = tens_q;
    bcd_d       = bcd_q;
    valid_d     = 1'b0;
    seg_err_d   = 1'b0;
    anode_err_d = 1'b0;

    if (state_q == ST_COMPLETE) begin
      state_d = ST_EMPTY;
    end else if (stb_q) begin
      case (samp_an)
        2'b00: anode_err_d = 1'b1;
        2'b10, 2'b01: begin
          if (!dec[4]) begin
            seg_err_d = 1'b1;
          end else if (samp_an == 2'b10) begin
            units_d = dec[3:0];
            case (state_q)
              ST_HAVE_T: state_d = ST_COMPLETE;
              default:   state_d = ST_HAVE_U;
            endcase
          end else begin
            tens_d = dec[3:0];
            case (state_q)
              ST_HAVE_U: state_d = ST_COMPLETE;
              default:   state_d = ST_HAVE_T;
            endcase
          end
        end
        default: ;
      endcase
    end

    if (state_d == ST_COMPLETE) begin
      valid_d = 1'b1;
      bcd_d   = {tens_d, units_d};
    end
  end

  // Refresh watchdog: saturating count since the last completed pair.
  always_comb begin
    to_d = to_q;
    if (valid_d) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + TO_W'(1);
    end
    stale_d = (to_d == TO_MAX);
  end

  // All state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      samp_q      <= '0;
      cnt_q       <= '0;
      stb_q       <= 1'b0;
      state_q     <= ST_EMPTY;
      units_q     <= '0;
      tens_q      <= '0;
      bcd_q       <= '0;
      valid_q     <= 1'b0;
      seg_err_q   <= 1'b0;
      anode_err_q <= 1'b0;
      to_q        <= '0;
      stale_q     <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      state_q     <= state_d;
      units_q     <= units_d;
      tens_q      <= tens_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      seg_err_q   <= seg_err_d;
      anode_err_q <= anode_err_d;
      to_q        <= to_d;
      stale_q     <= stale_d;
    end
  end

  assign bcd_o       = bcd_q;
  assign valid_o     = valid_q;
  assign seg_err_o   = seg_err_q;
  assign anode_err_o = anode_err_q;
  assign stale_o     = stale_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with hand-computed expectations.
module tb_seg7_capture;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [1:0] anodo_i;
  logic [6:0] catodo_i;
  logic [7:0] bcd_o;
  logic       valid_o;
  logic       seg_err_o;
  logic       anode_err_o;
  logic       stale_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_seg    = 0;
  int n_an     = 0;
  int snap_v, snap_s, snap_a;

  seg7_capture #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .anodo_i    (anodo_i),
    .catodo_i   (catodo_i),
    .bcd_o      (bcd_o),
    .valid_o    (valid_o),
    .seg_err_o  (seg_err_o),
    .anode_err_o(anode_err_o),
    .stale_o    (stale_o)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid_o)     n_valid++;
    if (seg_err_o)   n_seg++;
    if (anode_err_o) n_an++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [1:0] an, input logic [6:0] cat);
    anodo_i  = an;
    catodo_i = cat;
  endtask

  task automatic dwell(input logic [1:0] an, input logic [6:0] cat, input int n);
    put(an, cat);
    tick(n);
  endtask

  // Applies the completing digit and checks the 5-cycle valid latency.
  task automatic finish_pair(input string tag, input logic [1:0] an, input logic [6:0] cat,
                             input logic [7:0] exp_bcd);
    put(an, cat);
    tick(4);
    check_eq({tag, "_valid_early"}, 32'(valid_o), 32'd0);
    tick(1);
    check_eq({tag, "_valid"}, 32'(valid_o), 32'd1);
    check_eq({tag, "_bcd"}, 32'(bcd_o), 32'(exp_bcd));
    tick(1);
    check_eq({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
    tick(4);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset with random inputs, then idle on blank anodes.
    rst_i = 1'b1;
    put(2'b11, 7'h7F);
    repeat (3) begin
      anodo_i  = 2'($urandom);
      catodo_i = 7'($urandom);
      tick(1);
    end
    check_eq("rst_bcd", 32'(bcd_o), 32'h00);
    check_eq("rst_flags", 32'({valid_o, seg_err_o, anode_err_o, stale_o}), 32'd0);
    put(2'b11, 7'h7F);
    snap_v = n_valid; snap_s = n_seg; snap_a = n_an;
    rst_i = 1'b0;
    tick(12);
    check_eq("idle_valid_cnt", 32'(n_valid - snap_v), 32'd0);
    check_eq("idle_err_cnt", 32'((n_seg - snap_s) + (n_an - snap_a)), 32'd0);
    check_eq("idle_stale", 32'(stale_o), 32'd0);

    // 2. Normal pair 5/3 -> 35, then three more repetitions.
    snap_v = n_valid;
    dwell(2'b10, 7'h12, 10);
    finish_pair("pair", 2'b01, 7'h30, 8'h35);
    check_eq("pair_cnt", 32'(n_valid - snap_v), 32'd1);
    snap_v = n_valid;
    for (int i = 0; i < 3; i++) begin
      dwell(2'b10, 7'h12, 10);
      dwell(2'b01, 7'h30, 10);
    end
    check_eq("repeat_cnt", 32'(n_valid - snap_v), 32'd3);

    // 3. Short glitch to an '8' pattern at the end of the units dwell.
    snap_v = n_valid;
    snap_s = n_seg;
    dwell(2'b10, 7'h12, 10);
    dwell(2'b10, 7'h00, 3);
    finish_pair("glitch", 2'b01, 7'h30, 8'h35);
    check_eq("glitch_cnt", 32'(n_valid - snap_v), 32'd1);
    check_eq("glitch_seg", 32'(n_seg - snap_s), 32'd0);

    // 4. Blank segments and an illegal anode code.
    snap_v = n_valid; snap_s = n_seg; snap_a = n_an;
    put(2'b10, 7'h7F);
    tick(4);
    check_eq("seg_err_early", 32'(seg_err_o), 32'd0);
    tick(1);
    check_eq("seg_err_pulse", 32'(seg_err_o), 32'd1);
    tick(1);
    check_eq("seg_err_drop", 32'(seg_err_o), 32'd0);
    tick(4);
    put(2'b00, 7'h12);
    tick(5);
    check_eq("anode_err_pulse", 32'(anode_err_o), 32'd1);
    tick(5);
    check_eq("err_seg_cnt", 32'(n_seg - snap_s), 32'd1);
    check_eq("err_an_cnt", 32'(n_an - snap_a), 32'd1);
    dwell(2'b01, 7'h30, 10);
    check_eq("err_no_advance", 32'(n_valid - snap_v), 32'd0);
    finish_pair("err_recover", 2'b10, 7'h79, 8'h31);

    // 5. Overwrite of a held digit, units-first then tens-first.
    snap_v = n_valid;
    dwell(2'b10, 7'h79, 10);
    dwell(2'b10, 7'h24, 10);
    finish_pair("ovw_u", 2'b01, 7'h02, 8'h62);
    check_eq("ovw_u_cnt", 32'(n_valid - snap_v), 32'd1);
    snap_v = n_valid;
    dwell(2'b01, 7'h30, 10);
    dwell(2'b01, 7'h02, 10);
    finish_pair("ovw_t", 2'b10, 7'h24, 8'h62);
    check_eq("ovw_t_cnt", 32'(n_valid - snap_v), 32'd1);

    // 6a. Stale detection after TIMEOUT cycles without a pair.
    dwell(2'b10, 7'h12, 10);
    put(2'b01, 7'h30);
    tick(5);
    check_eq("stale_ref_valid", 32'(valid_o), 32'd1);
    put(2'b11, 7'h7F);
    tick(TIMEOUT - 1);
    check_eq("stale_early", 32'(stale_o), 32'd0);
    tick(1);
    check_eq("stale_rise", 32'(stale_o), 32'd1);
    dwell(2'b10, 7'h19, 10);
    put(2'b01, 7'h10);
    tick(4);
    check_eq("stale_hold", 32'(stale_o), 32'd1);
    tick(1);
    check_eq("stale_clr_valid", 32'(valid_o), 32'd1);
    check_eq("stale_clr", 32'(stale_o), 32'd0);
    check_eq("stale_clr_bcd", 32'(bcd_o), 32'h94);
    tick(5);

    // 6b. Asynchronous reset while holding a units digit.
    snap_v = n_valid;
    dwell(2'b10, 7'h12, 10);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("arst_bcd", 32'(bcd_o), 32'h00);
    check_eq("arst_flags", 32'({valid_o, seg_err_o, anode_err_o, stale_o}), 32'd0);
    tick(2);
    rst_i = 1'b0;
    dwell(2'b01, 7'h30, 10);
    check_eq("arst_discard", 32'(n_valid - snap_v), 32'd0);
    finish_pair("arst_pair", 2'b10, 7'h78, 8'h37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
